// File: rtl/dft_bin_capture.sv
// Captures one DFT output frame as per-bin magnitudes into a ping-pong store for display readout.
// Define DFT_BIN_CAPTURE_PEAK_EN to add the peak_bin/peak_mag tracker outputs.
module dft_bin_capture #(
  parameter int BINS = 24,
  parameter int DW   = 18
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic [DW-1:0] xk_re,
  input  logic [DW-1:0] xk_im,
  input  logic          fd_out,
  input  logic          data_valid,
  input  logic [4:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_done,
  output logic          frame_err,
`ifdef DFT_BIN_CAPTURE_PEAK_EN
  output logic [7:0]    frame_cnt,
  output logic [4:0]    peak_bin,
  output logic [DW-1:0] peak_mag
`else
  output logic [7:0]    frame_cnt
`endif
);

  localparam logic [4:0] LAST_BIN = 5'(BINS - 1);
  localparam logic [5:0] BINS_W   = 6'(BINS);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  state_t     state, state_nx;
  logic [4:0] bin_idx, bin_idx_nx, sample_bin;
  logic       flush_cnt, flush_nx;
  logic       take, abort, swap;

  logic          s1_valid, s2_valid;
  logic [4:0]    s1_bin, s2_bin;
  logic [DW-1:0] s1_a, s1_b, s2_mag;
  logic [DW-1:0] mag_max, mag_min, mag_sat;
  logic [DW:0]   mag_sum;

  logic          disp_sel, cap_sel;
  logic [1:0]    bank_full;
  logic [DW-1:0] bank_mem [2][BINS];

  function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] x);
    return x[DW-1] ? ((~x) + DW'(1)) : x;
  endfunction

  // Frame sequencing: any sample is taken at sample_bin, which is 0 on frame start or abort.
  always_comb begin
    state_nx   = state;
    bin_idx_nx = bin_idx;
    flush_nx   = flush_cnt;
    sample_bin = bin_idx;
    take       = 1'b0;
    abort      = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (fd_out || data_valid) begin
          state_nx   = CAPTURE;
          bin_idx_nx = '0;
          sample_bin = '0;
          take       = data_valid;
        end
      end
      CAPTURE: begin
        if (fd_out) begin
          abort      = 1'b1;
          bin_idx_nx = '0;
          sample_bin = '0;
        end
        take = data_valid;
      end
      FLUSH: begin
        if (flush_cnt) begin
          state_nx = IDLE;
          swap     = 1'b1;
          flush_nx = 1'b0;
        end else begin
          flush_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (take) begin
      if (sample_bin == LAST_BIN) begin
        state_nx   = FLUSH;
        bin_idx_nx = '0;
        flush_nx   = 1'b0;
      end else begin
        bin_idx_nx = sample_bin + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state      <= IDLE;
      bin_idx    <= '0;
      flush_cnt  <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      disp_sel   <= 1'b0;
      bank_full  <= '0;
    end else begin
      state      <= state_nx;
      bin_idx    <= bin_idx_nx;
      flush_cnt  <= flush_nx;
      frame_done <= swap;
      if (abort)
        frame_err <= 1'b1;
      if (swap) begin
        disp_sel           <= ~disp_sel;
        bank_full[cap_sel] <= 1'b1;
        frame_cnt          <= frame_cnt + 8'd1;
      end
    end
  end

  assign cap_sel = ~disp_sel;

  // Alpha-max-plus-half-beta-min estimate; the sum is one bit wider so saturation is explicit.
  always_comb begin
    mag_max = (s1_a >= s1_b) ? s1_a : s1_b;
    mag_min = (s1_a >= s1_b) ? s1_b : s1_a;
    mag_sum = {1'b0, mag_max} + {2'b00, mag_min[DW-1:1]};
    mag_sat = mag_sum[DW] ? '1 : mag_sum[DW-1:0];
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_mag   <= '0;
    end else begin
      s1_valid <= take;
      s1_bin   <= sample_bin;
      s1_a     <= abs_val(xk_re);
      s1_b     <= abs_val(xk_im);
      s2_valid <= s1_valid;
      s2_bin   <= s1_bin;
      s2_mag   <= mag_sat;
    end
  end

  // The last write of a frame lands on the same edge as the swap, still into the old capture bank.
  always_ff @(posedge clk) begin
    if (s2_valid)
      bank_mem[cap_sel][s2_bin] <= s2_mag;
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr)
      rd_data <= '0;
    else if (({1'b0, rd_addr} < BINS_W) && bank_full[disp_sel])
      rd_data <= bank_mem[disp_sel][rd_addr];
    else
      rd_data <= '0;
  end

`ifdef DFT_BIN_CAPTURE_PEAK_EN
  logic [DW-1:0] run_mag, run_mag_nx;
  logic [4:0]    run_bin, run_bin_nx;

  // Bins arrive in ascending order, so a strict compare keeps the lowest index on ties.
  always_comb begin
    run_mag_nx = run_mag;
    run_bin_nx = run_bin;
    if (s2_valid) begin
      if (s2_bin == 5'd0) begin
        run_mag_nx = '0;
        run_bin_nx = '0;
      end else if ((s2_bin == 5'd1) || (s2_mag > run_mag)) begin
        run_mag_nx = s2_mag;
        run_bin_nx = s2_bin;
      end
    end
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      run_mag  <= '0;
      run_bin  <= '0;
      peak_mag <= '0;
      peak_bin <= '0;
    end else begin
      run_mag <= run_mag_nx;
      run_bin <= run_bin_nx;
      if (swap) begin
        peak_mag <= run_mag_nx;
        peak_bin <= run_bin_nx;
      end
    end
  end
`endif

endmodule
